i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: slave

---
 rtl/i2c_slave.sv | 168 ++++++++++++++++
 tb/tb_i2c_slave.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address, master write into data_out, master read from data_in.
// Optional general-call (address 7'h00, write only) via `define I2C_SLAVE_GENERAL_CALL_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       tx_load,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] RX       = 3'd3;
  localparam logic [2:0] RX_ACK   = 3'd4;
  localparam logic [2:0] TX       = 3'd5;
  localparam logic [2:0] TX_ACK   = 3'd6;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       rw;
  logic       ack_phase;

  logic scl, sda, scl_rise, scl_fall, start_c, stop_c;
  logic gc_match, addr_match;

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SCL must be stably high across both samples, so START/STOP never coincide with an SCL edge
  assign start_c  = scl & scl_d & sda_d & ~sda;
  assign stop_c   = scl & scl_d & ~sda_d & sda;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign gc_match = (shreg[6:0] == 7'h00) & ~sda;
`else
  assign gc_match = 1'b0;
`endif
  // evaluated on the 8th ADDR rise: shreg[6:0] holds the address, sda is R/W
  assign addr_match = (shreg[6:0] == SLAVE_ADDR) | gc_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      state     <= IDLE;
      sda_out   <= 1'b1;
      data_out  <= 8'h00;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      cnt       <= 3'd0;
      shreg     <= 8'h00;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], sclk};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl;
      sda_d    <= sda;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (start_c) begin
        state     <= ADDR;
        cnt       <= 3'd0;
        sda_out   <= 1'b1;
        ack_phase <= 1'b0;
      end else if (stop_c) begin
        state     <= IDLE;
        cnt       <= 3'd0;
        sda_out   <= 1'b1;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rw        <= sda;
              ack_phase <= 1'b0;
              state     <= addr_match ? ADDR_ACK : IDLE;
            end
          end
          // ack states: first SCL fall drives the ACK, rise marks the ACK clock, next fall exits
          ADDR_ACK: begin
            if (scl_rise) ack_phase <= 1'b1;
            else if (scl_fall) begin
              if (!ack_phase) sda_out <= 1'b0;
              else begin
                ack_phase <= 1'b0;
                if (rw) begin
                  shreg   <= {data_in[6:0], 1'b0};
                  sda_out <= data_in[7];
                  tx_load <= 1'b1;
                  state   <= TX;
                end else begin
                  sda_out <= 1'b1;
                  state   <= RX;
                end
              end
            end
          end
          RX: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              data_out  <= {shreg[6:0], sda};
              rx_valid  <= 1'b1;
              ack_phase <= 1'b0;
              state     <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_rise) ack_phase <= 1'b1;
            else if (scl_fall) begin
              if (!ack_phase) sda_out <= 1'b0;
              else begin
                ack_phase <= 1'b0;
                sda_out   <= 1'b1;
                state     <= RX;
              end
            end
          end
          TX: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                ack_phase <= 1'b0;
                state     <= TX_ACK;
              end
            end else if (scl_fall) begin
              sda_out <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda) state <= IDLE;
              else     ack_phase <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_phase) sda_out <= 1'b1;
              else begin
                ack_phase <= 1'b0;
                shreg     <= {data_in[6:0], 1'b0};
                sda_out   <= data_in[7];
                tx_load   <= 1'b1;
                state     <= TX;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master with a transaction-level model; rx_valid/tx_load events are scoreboarded.
module tb_i2c_slave;

  localparam logic [6:0] SA = 7'h50;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  localparam int Q = 40;
  localparam int H = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_out;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       rx_valid, tx_load;
  logic [2:0] state;
  wire        bus = sda_m & sda_out;

  i2c_slave #(.SLAVE_ADDR(SA)) dut (
    .clk(clk), .rst(rst), .sclk(scl_m), .sda_in(bus), .sda_out(sda_out),
    .data_in(data_in), .data_out(data_out), .rx_valid(rx_valid),
    .tx_load(tx_load), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int low_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] buf_d[4];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every DUT event must have a queued expectation
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      chk("rx_valid_expected", int'(exp_rx.size() > 0), 1);
      if (exp_rx.size() > 0) chk("rx_data", data_out, exp_rx.pop_front());
    end
    if (!rst && tx_load) begin
      chk("tx_load_expected", int'(exp_tx.size() > 0), 1);
      if (exp_tx.size() > 0) chk("tx_load_data", data_in, exp_tx.pop_front());
    end
  end

  always @(posedge clk) if (sda_out == 1'b0) low_cnt <= low_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic bit_xfer(input bit b, output bit r);
    sda_m = b; #Q;
    scl_m = 1'b1; #H;
    r = bus;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b0; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b1; #H;
  endtask

  task automatic wr_byte(input logic [7:0] b, output bit ack);
    bit r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(output logic [7:0] rb);
    bit r;
    rb = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      rb = {rb[6:0], r};
    end
  endtask

  // full transaction; expectations derived from address/rw rules only
  task automatic xact(input logic [6:0] a, input bit rw, input int n);
    bit m, ack;
    int low0;
    logic [7:0] rb;
    m = (a == SA) || (GC && a == 7'h00 && !rw);
    low0 = low_cnt;
    if (rw) begin
      data_in = buf_d[0];
      if (m) exp_tx.push_back(buf_d[0]);
    end
    i2c_start();
    wr_byte({a, rw}, ack);
    chk("addr_ack", ack, int'(!m));
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        if (m) exp_rx.push_back(buf_d[i]);
        wr_byte(buf_d[i], ack);
        chk("data_ack", ack, int'(!m));
      end
    end else if (m) begin
      for (int i = 0; i < n; i++) begin
        rd_byte(rb);
        chk("rd_byte", rb, buf_d[i]);
        if (i < n - 1) begin
          data_in = buf_d[i+1];
          exp_tx.push_back(buf_d[i+1]);
          bit_xfer(1'b0, ack);
        end else bit_xfer(1'b1, ack);
      end
    end
    i2c_stop();
    #H;
    chk("idle_state", state, 0);
    chk("sda_released", sda_out, 1);
    if (!m) chk("never_low", low_cnt - low0, 0);
    chk("rx_pending", exp_rx.size(), 0);
    chk("tx_pending", exp_tx.size(), 0);
  endtask

  initial begin
    bit ack, r;
    logic [7:0] rb;
    logic [6:0] a;
    repeat (4) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_sda", sda_out, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_load", tx_load, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write 0xA5
    buf_d[0] = 8'hA5;
    xact(SA, 1'b0, 1);
    chk("wr_data_out", data_out, 8'hA5);
    // read 0xF6 then 0x3C
    buf_d[0] = 8'hF6; buf_d[1] = 8'h3C;
    xact(SA, 1'b1, 2);
    // wrong address
    buf_d[0] = 8'h77;
    xact(7'h23, 1'b0, 1);
    // general call write 0x11
    buf_d[0] = 8'h11;
    xact(7'h00, 1'b0, 1);
    chk("gc_data_out", data_out, GC ? 8'h11 : 8'h3C & 8'h00 | 8'hA5);
    // general call read is never acknowledged
    buf_d[0] = 8'h5A;
    xact(7'h00, 1'b1, 1);

    // partial write, repeated start, then read
    i2c_start();
    wr_byte({SA, 1'b0}, ack);
    chk("rs_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom_range(0, 1)), r);
    data_in = 8'hC3;
    exp_tx.push_back(8'hC3);
    i2c_start();
    chk("rs_state_addr", state, 1);
    wr_byte({SA, 1'b1}, ack);
    chk("rs_read_ack", ack, 0);
    rd_byte(rb);
    chk("rs_rd_byte", rb, 8'hC3);
    bit_xfer(1'b1, ack);
    i2c_stop();
    #H;
    chk("rs_idle", state, 0);
    chk("rs_tx_pending", exp_tx.size(), 0);

    // reset during RX bit 5
    i2c_start();
    wr_byte({SA, 1'b0}, ack);
    chk("rst_mid_ack", ack, 0);
    for (int i = 0; i < 5; i++) bit_xfer(1'($urandom_range(0, 1)), r);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_sda", sda_out, 1);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_data_out", data_out, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom_range(0, 1)), r);
    chk("rst_mid_ignored", state, 0);
    i2c_stop();
    #H;

    // randomized transactions
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = SA;
        2:       a = 7'($urandom_range(1, 127));
        default: a = 7'h00;
      endcase
      for (int i = 0; i < 4; i++) buf_d[i] = 8'($urandom);
      xact(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
